// File: rtl/inst_axi_read_bridge_pkg.sv
// Shared constants for the instruction-fetch AXI read bridge.
// The optional read-error flag is enabled with the INST_BRIDGE_RERR_EN macro.
package inst_axi_read_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    localparam int MAX_OUTSTANDING_LIMIT = 3;

    // Outstanding counter must represent 0..max_out inclusive.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/inst_axi_read_bridge_if.sv
// Bundles the IF-stage SRAM-like port and the AXI AR/R channels of the bridge.
// inst_sram_err exists only when INST_BRIDGE_RERR_EN is defined.
interface inst_axi_read_bridge_if;

    // A transfer happens on every cycle where valid (req/arvalid/rvalid) and
    // ready (addr_ok/arready/rready) are both high; valid never drops early.
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
`ifdef INST_BRIDGE_RERR_EN
    logic        inst_sram_err;
`endif

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
`ifdef INST_BRIDGE_RERR_EN
        output inst_sram_err,
`endif
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
        input  inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
`ifdef INST_BRIDGE_RERR_EN
        input  inst_sram_err,
`endif
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
        output inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/inst_axi_read_bridge.sv
// Converts IF-stage SRAM-like fetches into single-beat AXI4 reads, in order.
// Define INST_BRIDGE_RERR_EN to report non-OKAY rresp on inst_sram_err.
module inst_axi_read_bridge
    import inst_axi_read_bridge_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AR_ID           = 4'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    inst_axi_read_bridge_if.master bus,
    output logic [1:0]             dbg_cnt
);

    localparam int                 CNT_W   = cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             arvalid_r;
    logic [31:0]      araddr_r;
    logic [2:0]       arsize_r;
    logic             data_ok_r;
    logic [31:0]      rdata_r;
    logic             accept;
    logic             r_fire;

    assign bus.inst_sram_addr_ok = bus.inst_sram_req & ~bus.inst_sram_wr & ~arvalid_r
                                 & (cnt < CNT_MAX);
    assign accept = bus.inst_sram_addr_ok;
    assign bus.rready = (cnt != '0);
    assign r_fire = bus.rvalid & bus.rready;

    assign bus.arid    = AR_ID;
    assign bus.araddr  = araddr_r;
    assign bus.arlen   = 8'd0;
    assign bus.arsize  = arsize_r;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'h0;
    assign bus.arprot  = 3'h0;
    assign bus.arvalid = arvalid_r;

    assign bus.inst_sram_data_ok = data_ok_r;
    assign bus.inst_sram_rdata   = rdata_r;
    assign dbg_cnt               = 2'(cnt);

    // cnt covers a read from acceptance until its data_ok, so it bounds both
    // the AR slot and the single registered R beat.
    always_comb begin
        cnt_next = cnt;
        if (accept && !data_ok_r) begin
            cnt_next = cnt + CNT_W'(1);
        end else if (!accept && data_ok_r) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            arvalid_r <= 1'b0;
            araddr_r  <= 32'h0;
            arsize_r  <= AXI_SIZE_WORD;
            data_ok_r <= 1'b0;
            rdata_r   <= 32'h0;
        end else begin
            cnt       <= cnt_next;
            data_ok_r <= r_fire;
            if (accept) begin
                arvalid_r <= 1'b1;
                araddr_r  <= bus.inst_sram_addr;
                arsize_r  <= {1'b0, bus.inst_sram_size};
            end else if (arvalid_r && bus.arready) begin
                arvalid_r <= 1'b0;
            end
            if (r_fire) begin
                rdata_r <= bus.rdata;
            end
        end
    end

`ifdef INST_BRIDGE_RERR_EN
    logic err_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 1'b0;
        end else begin
            err_r <= r_fire & (bus.rresp != AXI_RESP_OKAY);
        end
    end

    assign bus.inst_sram_err = err_r;

    logic unused_inputs;
    assign unused_inputs = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rlast};
`else
    logic unused_inputs;
    assign unused_inputs = ^{bus.inst_sram_wstrb, bus.inst_sram_wdata, bus.rid, bus.rlast,
                             bus.rresp};
`endif

endmodule

// File: doc/inst_axi_read_bridge.md
# inst_axi_read_bridge

Converts the fetch stage's SRAM-like instruction request/response interface (req/addr_ok/data_ok) into an AXI4 read-only master (AR and R channels). It sits directly downstream of the IF stage's `inst_sram_*` port and upstream of the system AXI interconnect. It supports up to `MAX_OUTSTANDING` in-flight reads and returns data in request order. Flush and cancel handling stays in IF: every accepted request produces exactly one `data_ok`.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2, maximum number of accepted reads whose `data_ok` has not yet fired. Legal range is 1–3.
- `AR_ID`, default 4'd0, constant value driven on `arid`.

Ports:
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `inst_sram_req` input 1: IF request valid.
- `inst_sram_wr` input 1: write flag. Writes are never accepted.
- `inst_sram_size` input 2: transfer size; 2'b10 means a 32-bit word.
- `inst_sram_wstrb` input 4: ignored.
- `inst_sram_addr` input 32: physical fetch address.
- `inst_sram_wdata` input 32: ignored.
- `inst_sram_addr_ok` output 1: request accepted this cycle.
- `inst_sram_data_ok` output 1: `inst_sram_rdata` is valid this cycle.
- `inst_sram_rdata` output 32: returned instruction word.
- `arid` output 4: AR channel ID.
- `araddr` output 32: AR address.
- `arlen` output 8: burst length.
- `arsize` output 3: beat size.
- `arburst` output 2: burst type.
- `arlock` output 2: lock type.
- `arcache` output 4: cache attributes.
- `arprot` output 3: protection attributes.
- `arvalid` output 1: AR valid.
- `arready` input 1: AR ready.
- `rid` input 4: R channel ID.
- `rdata` input 32: R data.
- `rresp` input 2: R response.
- `rlast` input 1: last beat.
- `rvalid` input 1: R valid.
- `rready` output 1: R ready.
- `inst_sram_err` output 1: registered error flag. Present only with `INST_BRIDGE_RERR_EN`.

## Operation
Request acceptance:
- `addr_ok = req & ~wr & ~arvalid & (cnt < MAX_OUTSTANDING)`. This is combinational from the inputs and the registered state.
- On `req & addr_ok`, the bridge latches `araddr <= addr` and `arsize <= {1'b0, size}`, and sets `arvalid <= 1`.
- AR slot: `arvalid` holds, with `araddr` and `arsize` stable, until `arvalid & arready`. `arvalid` then clears. No new request is accepted while `arvalid` = 1.

Constant AR fields:
- `arlen` = 0.
- `arburst` = 2'b01 (INCR).
- `arlock` = 0.
- `arcache` = 0.
- `arprot` = 0.
- `arid` = `AR_ID`.

Outstanding counter `cnt`:
- 2-bit counter.
- Increments on `req & addr_ok`.
- Decrements on `data_ok`.
- Holds when both happen in the same cycle.
- Never exceeds `MAX_OUTSTANDING` and never underflows.

R channel:
- `rready` = 1 whenever `cnt != 0`, otherwise 0.
- On `rvalid & rready` (single beat, `rlast` expected 1), the bridge registers `rdata_r <= rdata` and `data_ok_r <= 1`.
- `data_ok_r` is a one-cycle pulse. IF always absorbs `data_ok`, so no back-pressure toward IF exists.
- `rid` is ignored. The slave returns data in order because only one ID is used.
- Beats arriving while `cnt == 0` are protocol errors; `rready` = 0 in that case.

Write requests (`wr = 1`):
- `addr_ok` stays 0 indefinitely.
- No AXI activity is generated.

## Timing
- Reset values: `arvalid` = 0, `araddr` = 0, `arsize` = 3'b010, `rready` = 0, `addr_ok` = 0, `data_ok` = 0, `rdata` = 0, `cnt` = 0, `inst_sram_err` = 0.
- Minimum latency: a request accepted in cycle T gives `arvalid` in T+1. If `arready` is high in T+1, the R beat arrives no earlier than T+2, and `data_ok` fires at R beat + 1 cycle, i.e. T+3 at the earliest.
- Throughput: one request accepted every 2 cycles, because the AR slot is busy for at least 1 cycle after each accept.
- Counter boundaries:
  - With `cnt == MAX_OUTSTANDING`, `addr_ok` = 0 even when the AR slot is free.
  - A `data_ok` in cycle C allows acceptance in C only if `cnt < MAX_OUTSTANDING` held at the start of C. The counter is registered, so there is no same-cycle bypass.
- Reset mid-operation: all state clears in one cycle and pending beats are dropped. The AXI slave shares the same reset.

## Configuration
`INST_BRIDGE_RERR_EN`:
- Defined:
  - The `inst_sram_err` port exists.
  - The bridge registers `err <= (rresp != 2'b00)` alongside `rdata_r`.
  - `inst_sram_err` is valid only with `data_ok`; otherwise it is 0.
- Undefined:
  - The port is absent.
  - `rresp` is ignored.
  - Data is returned unchanged.

## Structure
Shared package contents:
- AXI constants: `AXI_BURST_INCR` = 2'b01, `AXI_RESP_OKAY` = 2'b00, `AXI_SIZE_WORD` = 3'b010.
- Counter width localparam: `$clog2(MAX_OUTSTANDING+1)`.

Sub-modules: none. The AR slot, counter and R register are coded in one module.

## Test plan
- Single fetch: request 0x1c000000, `arready` = 1, R beat with `rdata` = 0x02800000 one cycle later. Required: `addr_ok` at T, `arvalid` at T+1 with `araddr` = 0x1c000000, `data_ok` at T+3 with `rdata` = 0x02800000, `cnt` back to 0.
- AR stall: `arready` = 0 for 5 cycles. Required: `arvalid` and `araddr` stable throughout, `addr_ok` = 0 throughout, and the handshake completes when `arready` rises.
- Outstanding limit: 3 back-to-back requests (0x1c000000, 0x1c000004, 0x1c000008), R withheld. Required: 2 accepted, the third held until the first `data_ok`, and data returned in order.
- Simultaneous inc/dec: at `cnt` = 1, an accept coincides with `data_ok`. Required: `cnt` stays 1.
- Write request (`wr` = 1, `req` = 1) for 10 cycles. Required: `addr_ok` = 0 and `arvalid` = 0 throughout.
- Reset mid-flight with `cnt` = 2. Required: next cycle `arvalid` = 0, `rready` = 0, `cnt` = 0, `data_ok` = 0.
- Error response, with `INST_BRIDGE_RERR_EN` defined: `rresp` = 2'b10. Required: `inst_sram_err` = 1 coincident with `data_ok`.
